// File: rtl/code_packer.sv
// code_packer: packs a stream of 12-bit LZW codes into bytes, two codes per
// three bytes, with a small input FIFO, ready/valid handshakes on both sides
// and a flush-driven end-of-stream sequence (odd trailing code padded).
module code_packer #(
  parameter int unsigned HASH_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HASH_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic                  flush,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  done,
  output logic [15:0]           byte_count
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    BYTE0,
    WAIT_B,
    BYTE1,
    BYTE2,
    PAD,
    DONE
  } state_t;

  state_t state_q, state_d;

  // input FIFO storage and bookkeeping
  logic [HASH_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           fill;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic [HASH_WIDTH-1:0] head;

  logic                  flush_q;
  logic                  xfer;

  // partial-byte holding registers between the two codes of a pair
  logic [3:0]            a_lo_q, a_lo_d;
  logic [7:0]            b_lo_q, b_lo_d;
  logic [7:0]            byte_d;
  logic                  valid_d;
  logic                  load_a;

  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FULL_CNT);
  assign head       = mem[rd_ptr];

  assign code_ready = !fifo_full && !flush_q;
  assign push       = code_valid && code_ready;
  assign xfer       = byte_valid && byte_ready;
  assign done       = (state_q == DONE);

  // FIFO storage: written on every accepted code, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= code_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // end-of-stream latch; once set it stays until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= 1'b0;
    end else if (flush && state_q != DONE) begin
      flush_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = BYTE0;
        end else if (flush_q) begin
          state_d = DONE;
        end
      end
      BYTE0: begin
        if (xfer) begin
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (!fifo_empty) begin
          state_d = BYTE1;
        end else if (flush_q) begin
          state_d = PAD;
        end
      end
      BYTE1: begin
        if (xfer) begin
          state_d = BYTE2;
        end
      end
      // BYTE2 chains straight into the next pair, so it mirrors IDLE's choice
      BYTE2: begin
        if (xfer) begin
          if (!fifo_empty) begin
            state_d = BYTE0;
          end else if (flush_q) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PAD: begin
        if (xfer) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: FIFO pops and next values for the byte registers
  always_comb begin
    pop     = 1'b0;
    load_a  = 1'b0;
    byte_d  = byte_out;
    valid_d = byte_valid;
    a_lo_d  = a_lo_q;
    b_lo_d  = b_lo_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_a = 1'b1;
        end
      end
      BYTE0: begin
        if (xfer) begin
          valid_d = 1'b0;
        end
      end
      WAIT_B: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = {a_lo_q, head[11:8]};
          b_lo_d  = head[7:0];
          valid_d = 1'b1;
        end else if (flush_q) begin
          byte_d  = {a_lo_q, 4'h0};
          valid_d = 1'b1;
        end
      end
      BYTE1: begin
        if (xfer) begin
          byte_d = b_lo_q;
        end
      end
      BYTE2: begin
        if (xfer) begin
          if (!fifo_empty) begin
            load_a = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      PAD: begin
        if (xfer) begin
          valid_d = 1'b0;
        end
      end
      DONE:    valid_d = 1'b0;
      default: valid_d = 1'b0;
    endcase
    // first code of a pair: IDLE and a completed BYTE2 share this action
    if (load_a) begin
      pop     = 1'b1;
      byte_d  = head[11:4];
      a_lo_d  = head[3:0];
      valid_d = 1'b1;
    end
  end

  // output byte register, pair holding registers and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      a_lo_q     <= '0;
      b_lo_q     <= '0;
      byte_count <= '0;
    end else begin
      byte_out   <= byte_d;
      byte_valid <= valid_d;
      a_lo_q     <= a_lo_d;
      b_lo_q     <= b_lo_d;
      if (xfer) begin
        byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule
